// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// master is the sequencer's view; slave is the MCU/ALU side.
interface alu_cmd_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int OP_WIDTH     = 4,
    parameter int REPEAT_WIDTH = 4
);
    logic                    CMD_VALID;
    logic                    CMD_READY;
    logic [DATA_WIDTH-1:0]   CMD_A;
    logic [DATA_WIDTH-1:0]   CMD_B;
    logic [OP_WIDTH-1:0]     CMD_OP;
    logic [REPEAT_WIDTH-1:0] CMD_REPEAT;

    logic [DATA_WIDTH-1:0]   ALU_IN_A;
    logic [DATA_WIDTH-1:0]   ALU_IN_B;
    logic [OP_WIDTH-1:0]     ALU_OP_CODE;
    logic [DATA_WIDTH-1:0]   ALU_RESULT;

    logic                    RSP_VALID;
    logic                    RSP_READY;
    logic [DATA_WIDTH-1:0]   RSP_DATA;
    logic                    BUSY;

    modport master (
        input  CMD_VALID, CMD_A, CMD_B, CMD_OP, CMD_REPEAT, ALU_RESULT, RSP_READY,
        output CMD_READY, ALU_IN_A, ALU_IN_B, ALU_OP_CODE, RSP_VALID, RSP_DATA, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_A, CMD_B, CMD_OP, CMD_REPEAT, ALU_RESULT, RSP_READY,
        input  CMD_READY, ALU_IN_A, ALU_IN_B, ALU_OP_CODE, RSP_VALID, RSP_DATA, BUSY
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one command (with optional repeats) to a 1-cycle-registered ALU,
// feeding each result back as the next A operand, and returns the final value.
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OP_WIDTH     = 4,
    parameter int REPEAT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    alu_cmd_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t                  state;
    logic [REPEAT_WIDTH-1:0] iter_cnt;
    logic [DATA_WIDTH-1:0]   alu_a_q;
    logic [DATA_WIDTH-1:0]   alu_b_q;
    logic [OP_WIDTH-1:0]     alu_op_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_valid_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            iter_cnt    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '1;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.CMD_VALID) begin
                        alu_a_q  <= bus.CMD_A;
                        alu_b_q  <= bus.CMD_B;
                        alu_op_q <= bus.CMD_OP;
                        iter_cnt <= bus.CMD_REPEAT;
                        state    <= ISSUE;
                    end
                end
                // The ALU registers its result on the edge that leaves ISSUE.
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    if (iter_cnt == '0) begin
                        rsp_data_q  <= bus.ALU_RESULT;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        alu_a_q  <= bus.ALU_RESULT;
                        iter_cnt <= iter_cnt - 1'b1;
                        state    <= ISSUE;
                    end
                end
                RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CMD_READY   = (state == IDLE);
    assign bus.BUSY        = (state != IDLE);
    assign bus.ALU_IN_A    = alu_a_q;
    assign bus.ALU_IN_B    = alu_b_q;
    assign bus.ALU_OP_CODE = alu_op_q;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_DATA    = rsp_data_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered ALU model.
module tb_alu_cmd_sequencer;

    logic clk;
    logic reset;
    logic [7:0] alu_res;
    int unsigned n_checks;
    int unsigned n_errors;
    logic [7:0] a_trace [16];

    alu_cmd_sequencer_if #(.DATA_WIDTH(8), .OP_WIDTH(4), .REPEAT_WIDTH(4)) bus ();

    alu_cmd_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(4), .REPEAT_WIDTH(4)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return p[7:0];
            4'h3:    return {a[6:0], 1'b0};
            4'h4:    return {1'b0, a[7:1]};
            4'h5:    return a + 8'd1;
            4'hA:    return {7'd0, (a > b)};
            default: return a;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) alu_res <= '0;
        else       alu_res <= alu_f(bus.ALU_IN_A, bus.ALU_IN_B, bus.ALU_OP_CODE);
    end
    assign bus.ALU_RESULT = alu_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [3:0] rep);
        bus.CMD_A      = a;
        bus.CMD_B      = b;
        bus.CMD_OP     = op;
        bus.CMD_REPEAT = rep;
        bus.CMD_VALID  = 1'b1;
    endtask

    // Accepts a command from IDLE, traces ALU_IN_A at every ISSUE, checks latency and data.
    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [3:0] rep, input logic [7:0] exp);
        int unsigned cyc;
        check({tag, "_ready"}, 32'(bus.CMD_READY), 32'd1);
        drive_cmd(a, b, op, rep);
        tick();
        bus.CMD_VALID = 1'b0;
        cyc = 0;
        while (!bus.RSP_VALID && cyc < 40) begin
            if (cyc % 2 == 0 && cyc / 2 < 16) a_trace[cyc/2] = bus.ALU_IN_A;
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, 32'(2 * (int'(rep) + 1)));
        check({tag, "_data"}, 32'(bus.RSP_DATA), 32'(exp));
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        check({tag, "_done"}, 32'(bus.RSP_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned rises;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.CMD_VALID  = 1'b0;
        bus.CMD_A      = '0;
        bus.CMD_B      = '0;
        bus.CMD_OP     = '0;
        bus.CMD_REPEAT = '0;
        bus.RSP_READY  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("rst_rsp_data", 32'(bus.RSP_DATA), 32'h00);
        check("rst_alu_a", 32'(bus.ALU_IN_A), 32'h00);
        check("rst_alu_b", 32'(bus.ALU_IN_B), 32'h00);
        check("rst_alu_op", 32'(bus.ALU_OP_CODE), 32'hF);

        // Single add with RSP_READY held high throughout
        bus.RSP_READY = 1'b1;
        drive_cmd(8'h12, 8'h34, 4'h0, 4'd0);
        tick();
        bus.CMD_VALID = 1'b0;
        check("add_alu_a", 32'(bus.ALU_IN_A), 32'h12);
        check("add_alu_b", 32'(bus.ALU_IN_B), 32'h34);
        check("add_alu_op", 32'(bus.ALU_OP_CODE), 32'h0);
        check("add_busy1", 32'(bus.BUSY), 32'd1);
        check("add_cmd_ready", 32'(bus.CMD_READY), 32'd0);
        check("add_rv1", 32'(bus.RSP_VALID), 32'd0);
        tick();
        check("add_busy2", 32'(bus.BUSY), 32'd1);
        check("add_rv2", 32'(bus.RSP_VALID), 32'd0);
        tick();
        check("add_busy3", 32'(bus.BUSY), 32'd1);
        check("add_rv3", 32'(bus.RSP_VALID), 32'd1);
        check("add_data", 32'(bus.RSP_DATA), 32'h46);
        tick();
        check("add_busy4", 32'(bus.BUSY), 32'd0);
        check("add_rv4", 32'(bus.RSP_VALID), 32'd0);
        bus.RSP_READY = 1'b0;
        tick();

        run_cmd("shl", 8'h01, 8'h00, 4'h3, 4'd3, 8'h10);
        check("shl_a0", 32'(a_trace[0]), 32'h01);
        check("shl_a1", 32'(a_trace[1]), 32'h02);
        check("shl_a2", 32'(a_trace[2]), 32'h04);
        check("shl_a3", 32'(a_trace[3]), 32'h08);
        check("shl_b_kept", 32'(bus.ALU_IN_B), 32'h00);
        check("shl_op_kept", 32'(bus.ALU_OP_CODE), 32'h3);

        run_cmd("inc_wrap", 8'hFE, 8'h00, 4'h5, 4'd2, 8'h01);
        run_cmd("mul_trunc", 8'h10, 8'h20, 4'h2, 4'd0, 8'h00);
        run_cmd("cmp", 8'h05, 8'h01, 4'hA, 4'd1, 8'h00);
        check("cmp_fb", 32'(a_trace[1]), 32'h01);
        run_cmd("rep_max", 8'h00, 8'h00, 4'h5, 4'd15, 8'h10);

        // Backpressure with a competing command held on CMD_VALID
        drive_cmd(8'h03, 8'h04, 4'h0, 4'd0);
        tick();
        drive_cmd(8'h20, 8'h01, 4'h0, 4'd0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rv", 32'(bus.RSP_VALID), 32'd1);
            check("bp_data", 32'(bus.RSP_DATA), 32'h07);
            check("bp_cmd_ready", 32'(bus.CMD_READY), 32'd0);
            check("bp_alu_a", 32'(bus.ALU_IN_A), 32'h03);
            tick();
        end
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        check("bp_release_ready", 32'(bus.CMD_READY), 32'd1);
        check("bp_release_rv", 32'(bus.RSP_VALID), 32'd0);
        tick();
        bus.CMD_VALID = 1'b0;
        check("bp2_alu_a", 32'(bus.ALU_IN_A), 32'h20);
        check("bp2_busy", 32'(bus.BUSY), 32'd1);
        tick();
        tick();
        check("bp2_rv", 32'(bus.RSP_VALID), 32'd1);
        check("bp2_data", 32'(bus.RSP_DATA), 32'h21);
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;

        // Reset during CAPTURE of the fourth iteration
        drive_cmd(8'h01, 8'h00, 4'h3, 4'd7);
        tick();
        bus.CMD_VALID = 1'b0;
        repeat (6) tick();
        check("mid_alu_a", 32'(bus.ALU_IN_A), 32'h08);
        tick();
        check("mid_in_capture_busy", 32'(bus.BUSY), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", 32'(bus.CMD_READY), 32'd1);
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_rv", 32'(bus.RSP_VALID), 32'd0);
        check("mid_rst_op", 32'(bus.ALU_OP_CODE), 32'hF);
        check("mid_rst_a", 32'(bus.ALU_IN_A), 32'h00);
        rises = 0;
        bus.RSP_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.RSP_VALID) rises++;
            tick();
        end
        bus.RSP_READY = 1'b0;
        check("mid_no_rsp", rises, 32'd0);

        run_cmd("post_rst", 8'h40, 8'h02, 4'h1, 4'd0, 8'h3E);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/opcode interface.
- Accepts one command per valid/ready handshake: operands A and B, opcode, and a repeat count.
- Drives the ALU's A, B and opcode inputs and captures its one-cycle-registered result.
- For repeated operations, feeds each result back as the next A; returns the final value on a valid/ready response port. Sits between the MCU control path and the ALU instance.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU.
OP_WIDTH, 4, opcode width; must match the ALU.
REPEAT_WIDTH, 4, width of the repeat-count field.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RESET  input  1  synchronous, active-high reset.
CMD_VALID  input  1  command present.
CMD_READY  output  1  sequencer can accept a command.
CMD_A  input  DATA_WIDTH  initial operand A.
CMD_B  input  DATA_WIDTH  operand B, constant for the whole command.
CMD_OP  input  OP_WIDTH  ALU opcode, constant for the whole command.
CMD_REPEAT  input  REPEAT_WIDTH  extra iterations; total executions = CMD_REPEAT+1.
ALU_IN_A  output  DATA_WIDTH  to ALU IN_A.
ALU_IN_B  output  DATA_WIDTH  to ALU IN_B.
ALU_OP_CODE  output  OP_WIDTH  to ALU opcode.
ALU_RESULT  input  DATA_WIDTH  from ALU OUT_RESULT (registered, 1-cycle latency).
RSP_VALID  output  1  result available.
RSP_READY  input  1  consumer takes result.
RSP_DATA  output  DATA_WIDTH  final result.
BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; takes effect at a CLK edge with RESET=1, from any state):
  - State goes to IDLE.
  - RSP_VALID=0, RSP_DATA=0, ALU_IN_A=0, ALU_IN_B=0, ALU_OP_CODE=4'hF (ALU pass-through default), iteration counter=0.
  - CMD_READY=1 and BUSY=0 from the first cycle after reset.
  - A command in flight is discarded; no response is produced.
- All ALU_* and RSP_* outputs are registered. CMD_READY and BUSY decode the state directly.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - CMD_READY=1.
  - On an edge with CMD_VALID=1: load ALU_IN_A<=CMD_A, ALU_IN_B<=CMD_B, ALU_OP_CODE<=CMD_OP, counter<=CMD_REPEAT; go to ISSUE.
  - CMD_VALID=0: remain in IDLE.
- ISSUE:
  - Operands are stable at the ALU; the ALU registers its result at this edge.
  - Go to CAPTURE unconditionally.
- CAPTURE:
  - ALU_RESULT is valid.
  - If counter==0: RSP_DATA<=ALU_RESULT, RSP_VALID<=1, go to RESP.
  - Else: ALU_IN_A<=ALU_RESULT, counter<=counter-1, go to ISSUE. ALU_IN_B and ALU_OP_CODE stay unchanged.
- RESP:
  - RSP_VALID=1; RSP_DATA is held stable until the handshake.
  - On an edge with RSP_READY=1: RSP_VALID<=0, go to IDLE.
  - The next command is accepted no earlier than the following cycle; no same-cycle turnaround.
- Latency and throughput:
  - Command accepted at edge t0 gives RSP_VALID high from edge t0+2*(CMD_REPEAT+1).
  - Each iteration costs exactly 2 cycles. Maximum is 32 cycles with REPEAT_WIDTH=4.
- CMD_READY=0 in ISSUE, CAPTURE and RESP. CMD_VALID asserted in those states is ignored, and command inputs are not sampled.
- Arithmetic wrap, truncation and compare encoding are the ALU's responsibility. The sequencer feeds back the 8-bit result unmodified, including 0x00/0x01 results of compare opcodes.
- The ALU instance must share CLK and RESET with this block.
- RSP_READY asserted while RSP_VALID=0 has no effect.

Test Plan:
- Single add: A=0x12, B=0x34, OP=0x0, REPEAT=0, RSP_READY=1 → ALU sees 0x12/0x34/0x0; RSP_VALID rises 2 cycles after accept with RSP_DATA=0x46; BUSY high for 3 cycles.
- Chained shift: A=0x01, OP=0x3, REPEAT=3 → ALU_IN_A sequence 0x01, 0x02, 0x04, 0x08; RSP_DATA=0x10 at accept+8 cycles.
- Wrap-around: A=0xFE, OP=0x5 (increment A), REPEAT=2 → RSP_DATA=0x01. Also A=0x10, B=0x20, OP=0x2 → RSP_DATA=0x00 (truncated multiply).
- Backpressure and busy: hold RSP_READY=0 for 5 cycles after RSP_VALID → RSP_VALID and RSP_DATA held, CMD_READY=0. A second CMD_VALID pulse during this time is not accepted. After RSP_READY=1, CMD_READY=1 on the next cycle, and the held command is then accepted.
- Reset mid-operation: start OP=0x3, REPEAT=7; assert RESET for 1 cycle in CAPTURE of iteration 3 → next cycle state IDLE, CMD_READY=1, RSP_VALID=0, ALU_OP_CODE=0xF, ALU_IN_A=0, no response ever emitted for that command.
- Compare chain: A=0x05, B=0x01, OP=0xA (A>B), REPEAT=1 → first result 0x01 fed back; 0x01>0x01 false; RSP_DATA=0x00.
